// File: rtl/pal_pkg.sv
// Shared types and sizes for the PAL sweep sequencer.
// Optional feature macro: PAL_SWEEP_SIG_EN (enables the output signature register).
package pal_pkg;

    localparam int unsigned N_VEC     = 16;
    localparam int unsigned PAL_IN_W  = 4;
    localparam int unsigned PAL_OUT_W = 5;
    localparam int unsigned SIG_W     = 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Rotate-left-by-one then fold in the captured PAL outputs.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0]     s,
                                                  input logic [PAL_OUT_W-1:0] f);
        return {s[SIG_W-2:0], s[SIG_W-1]} ^ SIG_W'(f);
    endfunction

endpackage

// File: rtl/pal_result_ram.sv
// 16x5 result table: one synchronous write port, one registered read port.
// Read-during-write to the same index returns the old contents.
module pal_result_ram
    import pal_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [PAL_OUT_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [PAL_OUT_W-1:0] rdata
);

    logic [PAL_OUT_W-1:0] mem [N_VEC];

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pal_sweep_ctrl.sv
// Sequencer that walks the PAL through all 16 input vectors, waits a settle
// time per vector, captures F1..F5 into a result table and pulses done.
// Optional feature macro: PAL_SWEEP_SIG_EN (running 8-bit output signature).
module pal_sweep_ctrl
    import pal_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [PAL_IN_W-1:0]  pal_in,
    input  logic [PAL_OUT_W-1:0] pal_out,
    output logic                 busy,
    output logic                 done,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [PAL_OUT_W-1:0] rd_data,
    output logic [SIG_W-1:0]     sig
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PAL_IN_W-1:0] pal_in_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                we_c;

    // State, index, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            pal_in <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            pal_in <= pal_in_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state and output decode; abort overrides any active state.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        pal_in_nxt = pal_in;
        we_c       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                pal_in_nxt = idx;
                cnt_nxt    = CNT_W'(SETTLE_CYCLES - 1);
                state_nxt  = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            CAPTURE: begin
                we_c = 1'b1;
                // Terminal test on the last index; idx never wraps mid-sweep.
                if (idx == ADDR_W'(N_VEC - 1)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + ADDR_W'(1);
                    state_nxt = DRIVE;
                end
            end
            DONE: begin
                pal_in_nxt = '0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort && (state inside {DRIVE, SETTLE, CAPTURE})) begin
            state_nxt  = IDLE;
            pal_in_nxt = '0;
        end

        busy_nxt = (state_nxt inside {DRIVE, SETTLE, CAPTURE});
        done_nxt = (state_nxt == DONE);
    end

`ifdef PAL_SWEEP_SIG_EN
    logic [SIG_W-1:0] sig_q, sig_nxt;

    // Signature: cleared on accepted start, folded on every capture, else held.
    always_comb begin
        sig_nxt = sig_q;
        if ((state == IDLE) && start) begin
            sig_nxt = '0;
        end else if (state == CAPTURE) begin
            sig_nxt = sig_step(sig_q, pal_out);
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_nxt;
        end
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

    pal_result_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_c),
        .waddr (idx),
        .wdata (pal_out),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_pal_sweep_ctrl.sv
// Scoreboard bench for pal_sweep_ctrl: stimulus pushes expected read data and
// done cycles into queues, a monitor pops and compares when the DUT presents them.
module tb_pal_sweep_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pal_in;
    logic [4:0] pal_out;
    logic       busy, done;
    logic [3:0] rd_addr = 4'd0;
    logic [4:0] rd_data;
    logic [7:0] sig;

    // Secondary instances for settle-time extremes.
    logic       start1 = 1'b0, start15 = 1'b0;
    logic [3:0] pal_in1, pal_in15;
    logic       busy1, done1, busy15, done15;
    logic [4:0] rd_data1, rd_data15;
    logic [7:0] sig1, sig15;

    int pal_mode = 0;   // 0: pass-through, 1: constant 00001, 2: {1,~ABCD}
    int pc       = 0;   // rising-edge counter
    int n_chk    = 0;
    int n_fail   = 0;

    int   rd_exp_q[$];
    int   done_exp_q[$];
    logic rd_issue = 1'b0;
    logic rd_pend  = 1'b0;

    always #5 clk = ~clk;

    assign pal_out = (pal_mode == 0) ? {1'b0, pal_in} :
                     (pal_mode == 1) ? 5'b00001 : {1'b1, ~pal_in};

    pal_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pal_in(pal_in), .pal_out(pal_out), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .sig(sig)
    );

    pal_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .pal_in(pal_in1), .pal_out({1'b0, pal_in1}), .busy(busy1), .done(done1),
        .rd_addr(4'd0), .rd_data(rd_data1), .sig(sig1)
    );

    pal_sweep_ctrl #(.SETTLE_CYCLES(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .start(start15), .abort(1'b0),
        .pal_in(pal_in15), .pal_out({1'b0, pal_in15}), .busy(busy15), .done(done15),
        .rd_addr(4'd0), .rd_data(rd_data15), .sig(sig15)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected PAL response for vector i under a given model.
    function automatic logic [4:0] pal_model(input int mode, input int i);
        logic [3:0] v;
        v = 4'(i);
        if (mode == 0) return {1'b0, v};
        if (mode == 1) return 5'b00001;
        return {1'b1, ~v};
    endfunction

    // Expected signature after n captures (zero when the feature is off).
    function automatic logic [7:0] sig_model(input int mode, input int n);
        logic [7:0] s;
        s = 8'h00;
`ifdef PAL_SWEEP_SIG_EN
        for (int i = 0; i < n; i++) begin
            s = {s[6:0], s[7]} ^ {3'b000, pal_model(mode, i)};
        end
`endif
        return s;
    endfunction

    always @(posedge clk) pc++;
    always @(posedge clk) rd_pend <= rd_issue;

    // Monitor: compare read data and done pulses against the scoreboard.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else                      check("rd_data", 32'(rd_data), 32'(rd_exp_q.pop_front()));
        end
        if (done === 1'b1) begin
            if (done_exp_q.size() == 0) check("done_unexpected", pc, 32'hFFFF_FFFF);
            else                        check("done_cycle", pc, 32'(done_exp_q.pop_front()));
        end
    end

    // Pulse start for one edge; p0 is the edge count right after that edge.
    task automatic start_sweep(output int p0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        p0    = pc;
        start = 1'b0;
    endtask

    // Advance to the falling edge inside cycle k of the sweep started at p0.
    task automatic wait_cyc(input int p0, input int k);
        @(negedge clk);
        while (pc < p0 + k - 1) @(negedge clk);
    endtask

    task automatic read_table(input int expv[16]);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr  = 4'(i);
            rd_issue = 1'b1;
            rd_exp_q.push_back(expv[i]);
        end
        @(negedge clk);
        rd_issue = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        int exp_pass[16];
        int exp_mix[16];
        int exp_one[16];
        int k1, k15;
        logic [7:0] sig8_exp;

        for (int i = 0; i < 16; i++) begin
            exp_pass[i] = i;
            exp_mix[i]  = (i < 5) ? (16 + 15 - i) : i;
            exp_one[i]  = 1;
        end
`ifdef PAL_SWEEP_SIG_EN
        sig8_exp = 8'hFF;
`else
        sig8_exp = 8'h00;
`endif

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pal_in", pal_in, 0);
        check("rst_sig", sig, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Pass-through sweep with a second start at cycle 20
        pal_mode = 0;
        start_sweep(p0);
        done_exp_q.push_back(p0 + 64);
        for (int v = 0; v < 16; v++) begin
            wait_cyc(p0, 4 + 4 * v);
            check("capture_pal_in", pal_in, v);
            check("capture_busy", busy, 1);
            if (v == 4) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("restart_ignored_busy", busy, 1);
            end
        end
        wait_cyc(p0, 66);
        check("post_done_busy", busy, 0);
        check("post_done_pal_in", pal_in, 0);
        check("pass_sig", sig, sig_model(0, 16));
        read_table(exp_pass);

        // Inverted model, abort in SETTLE of vector 5 (cycle 22)
        pal_mode = 2;
        start_sweep(p0);
        wait_cyc(p0, 22);
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pal_in", pal_in, 0);
        check("abort_sig", sig, sig_model(2, 5));
        wait_cyc(p0, 100);
        read_table(exp_mix);

        // Constant 00001 model: signature checkpoints
        pal_mode = 1;
        start_sweep(p0);
        done_exp_q.push_back(p0 + 64);
        wait_cyc(p0, 33);
        check("sig_after_8", sig, sig8_exp);
        wait_cyc(p0, 66);
        check("sig_after_done", sig, 8'h00);
        read_table(exp_one);

        // Asynchronous reset during CAPTURE of vector 9, then a fresh sweep
        pal_mode = 0;
        start_sweep(p0);
        wait_cyc(p0, 40);
        check("pre_reset_pal_in", pal_in, 9);
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_pal_in", pal_in, 0);
        check("async_sig", sig, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_sweep(p0);
        done_exp_q.push_back(p0 + 64);
        wait_cyc(p0, 66);
        check("resweep_sig", sig, sig_model(0, 16));
        read_table(exp_pass);

        // Settle-time extremes: done cycle 49 (S=1) and 273 (S=15)
        k1  = -1;
        k15 = -1;
        @(negedge clk);
        start1  = 1'b1;
        start15 = 1'b1;
        @(posedge clk);
        #1;
        start1  = 1'b0;
        start15 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done1 === 1'b1 && k1 < 0)   k1  = k;
            if (done15 === 1'b1 && k15 < 0) k15 = k;
        end
        check("done_cycle_s1", k1, 49);
        check("done_cycle_s15", k15, 273);

        check("rd_queue_drained", rd_exp_q.size(), 0);
        check("done_queue_drained", done_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pal_sweep_ctrl.md
# pal_sweep_ctrl

Sequencer that drives the 4-input PAL (inputs A,B,C,D; outputs F1–F5) through all 16 input combinations. It waits a programmable settle time per vector, captures the five outputs into a 16x5 result table, and signals completion. The table can be read back for truth-table checking. It sits between the PAL datapath and a host or self-test controller, so on-chip logic can characterise the PAL without a testbench loop.

## Interface
- SETTLE_CYCLES, 2: cycles pal_in is held stable before capture; legal range 1–15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  terminates a sweep in progress; ignored in IDLE.
- pal_in  out  4  drives {A,B,C,D} of the PAL; A is the MSB.
- pal_out  in  5  {F1,F2,F3,F4,F5} from the PAL; F1 is the MSB.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes normally.
- rd_addr  in  4  result-table read index.
- rd_data  out  5  table entry at rd_addr, registered (1-cycle latency).
- sig  out  8  running output signature (see Configuration).

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CAPTURE, DONE. Encoding is in the package.
- IDLE: when start=1, clear idx to 0, clear sig, and go to DRIVE.
- DRIVE (1 cycle): pal_in <= idx, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): count down; at 0 go to CAPTURE.
- CAPTURE (1 cycle): write pal_out into table[idx] and update sig.
  - If idx=15, go to DONE.
  - Otherwise idx <= idx+1 and go to DRIVE.
- idx is 4 bits and never wraps during a sweep. The terminal test is idx=15, not an overflow.
- DONE (1 cycle): done=1, pal_in <= 0, go to IDLE.
- abort in DRIVE, SETTLE or CAPTURE: go to IDLE on the next edge.
  - pal_in <= 0, no done pulse.
  - If abort coincides with CAPTURE, that entry is still written.
  - Other table entries keep their prior contents.
- abort and start together in IDLE: start wins; abort is ignored.
- start while busy: ignored, no queuing.
- busy = 1 in DRIVE, SETTLE and CAPTURE; busy = 0 in IDLE and DONE.
- Reads are allowed at any time. During a sweep a read returns the old or partially updated table.
- A read and a write to the same index in the same cycle return the old data.
- Reset values: state=IDLE, pal_in=0, busy=0, done=0, rd_data=0, sig=0, idx=0. Table contents are undefined after reset.

## Timing
- Each vector takes exactly SETTLE_CYCLES+2 cycles.
- Start is sampled at edge 0. DRIVE occupies cycle 1. pal_in is valid from edge 1.
- Capture samples pal_out at the final edge of CAPTURE, SETTLE_CYCLES+1 edges after pal_in changes.
- done is high during cycle 16·(SETTLE_CYCLES+2)+1. With the default SETTLE_CYCLES=2, that is cycle 65.
- rd_data reflects rd_addr sampled at the previous edge.
- Reset asserted mid-sweep forces all reset values immediately (asynchronous). After release the block is in IDLE.

## Configuration
- PAL_SWEEP_SIG_EN defined:
  - On each CAPTURE, sig <= {sig[6:0],sig[7]} ^ {3'b000,pal_out}.
  - sig is cleared on an accepted start.
  - sig is held after DONE or abort.
- PAL_SWEEP_SIG_EN undefined: no signature register; sig is tied to 8'h00. The port list is unchanged.

## Structure
- Package pal_pkg holds:
  - the state enum;
  - N_VEC=16, PAL_IN_W=4, PAL_OUT_W=5, SIG_W=8.
- Sub-module pal_result_ram: 16x5 storage, one synchronous write port and one registered read port, no reset on the array.
- FSM, counters and signature live in pal_sweep_ctrl.

## Test plan
- Pass-through model (F = {0,A,B,C,D}), start pulse:
  - pal_in steps 0..15, each held SETTLE_CYCLES+1 cycles;
  - done is high in cycle 65;
  - reading addresses 0..15 returns 0..15.
- Constant pal_out=5'b00001 with PAL_SWEEP_SIG_EN defined: sig=8'h00 after done; sig after the 8th capture = 8'hFF.
- abort asserted in the SETTLE of vector 5:
  - next cycle busy=0 and pal_in=0;
  - done never pulses;
  - entries 0–4 are written, entries 5–15 keep their prior values.
- start pulsed again at cycle 20 of a sweep: ignored; done still occurs exactly once, at cycle 65.
- rst_n dropped mid-CAPTURE of vector 9: busy, done, pal_in and sig go to 0 asynchronously; a fresh start then completes a full sweep.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15: done in cycle 49 and cycle 273 respectively.
